// File: rtl/input_cond_pkg.sv
// Shared types and constants for the board input conditioner.
package input_cond_pkg;

    typedef enum logic [1:0] {
        StFill,
        StPrime,
        StRun
    } startup_state_e;

    localparam logic KEY_IDLE = 1'b1;
    localparam logic SW_IDLE  = 1'b0;

    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One synchronised, debounced input channel with registered rise/fall strobes.
module debounce_channel
    import input_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    input  logic i_prime,
    input  logic i_run,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CntOne  = CW'(1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_rise;
    logic          r_fall;

    logic          w_stable_next;
    logic [CW-1:0] w_cnt_next;
    logic          w_rise_next;
    logic          w_fall_next;

    always_comb begin
        w_stable_next = r_stable;
        w_cnt_next    = r_cnt;
        w_rise_next   = 1'b0;
        w_fall_next   = 1'b0;
        if (i_prime) begin
            // Adopt whatever level is present at power-on without a strobe.
            w_stable_next = r_sync2;
            w_cnt_next    = '0;
        end else if (i_run) begin
            if (r_sync2 == r_stable) begin
                w_cnt_next = '0;
            end else if (r_cnt == CntLast) begin
                w_stable_next = r_sync2;
                w_cnt_next    = '0;
                w_rise_next   = r_sync2;
                w_fall_next   = ~r_sync2;
            end else begin
                w_cnt_next = r_cnt + CntOne;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1  <= RESET_LEVEL;
            r_sync2  <= RESET_LEVEL;
            r_stable <= RESET_LEVEL;
            r_cnt    <= '0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_sync1  <= i_raw;
            r_sync2  <= r_sync1;
            r_stable <= w_stable_next;
            r_cnt    <= w_cnt_next;
            r_rise   <= w_rise_next;
            r_fall   <= w_fall_next;
        end
    end

    assign o_level = r_stable;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/input_conditioner.sv
// Debounces DE2-115 KEY/SW inputs behind a FILL/PRIME/RUN startup sequence.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int unsigned N_KEYS          = 4,
    parameter int unsigned N_SW            = 18,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk_in_clk,
    input  logic              reset_in_reset_n,
    input  logic [N_KEYS-1:0] key_raw_n,
    input  logic [N_SW-1:0]   sw_raw,
    output logic [N_KEYS-1:0] key_n_out,
    output logic [N_SW-1:0]   sw_out,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_SW-1:0]   sw_change,
    output logic              ready
);

    startup_state_e r_state;
    startup_state_e w_state_next;
    logic           r_fill;
    logic           w_fill_next;
    logic           w_prime;
    logic           w_run;

    logic [N_SW-1:0] w_sw_rise;
    logic [N_SW-1:0] w_sw_fall;

    always_comb begin
        w_state_next = r_state;
        w_fill_next  = r_fill;
        unique case (r_state)
            StFill: begin
                // Two edges let both synchroniser stages capture the raw level.
                w_fill_next = 1'b1;
                if (r_fill) begin
                    w_state_next = StPrime;
                end
            end
            StPrime: w_state_next = StRun;
            StRun:   w_state_next = StRun;
            default: w_state_next = StFill;
        endcase
    end

    always_ff @(posedge clk_in_clk or negedge reset_in_reset_n) begin
        if (!reset_in_reset_n) begin
            r_state <= StFill;
            r_fill  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_fill  <= w_fill_next;
        end
    end

    assign w_prime = (r_state == StPrime);
    assign w_run   = (r_state == StRun);
    assign ready   = w_run;

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_LEVEL    (KEY_IDLE)
        ) u_chan (
            .i_clk  (clk_in_clk),
            .i_rst_n(reset_in_reset_n),
            .i_raw  (key_raw_n[gi]),
            .i_prime(w_prime),
            .i_run  (w_run),
            .o_level(key_n_out[gi]),
            .o_rise (key_release[gi]),
            .o_fall (key_press[gi])
        );
    end

    for (genvar gi = 0; gi < N_SW; gi++) begin : g_sw
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_LEVEL    (SW_IDLE)
        ) u_chan (
            .i_clk  (clk_in_clk),
            .i_rst_n(reset_in_reset_n),
            .i_raw  (sw_raw[gi]),
            .i_prime(w_prime),
            .i_run  (w_run),
            .o_level(sw_out[gi]),
            .o_rise (w_sw_rise[gi]),
            .o_fall (w_sw_fall[gi])
        );
    end

    assign sw_change = w_sw_rise | w_sw_fall;

endmodule
